seq_divider_32: RTL and testbench

- Multi-cycle 32-bit restoring divider controller that reuses a single Adder_32 instance in subtract mode (cin=1) as its only arithmetic resource.
- Sits beside the ALU and handles DIV/REM ops the single-cycle datapath cannot do.
- Valid/ready request and response handshakes, one operation in flight.

---
 rtl/div_pkg.sv | 25 ++
 rtl/Adder_32.sv | 26 ++
 rtl/seq_divider_32.sv | 183 ++++++++++++++++++
 tb/tb_seq_divider_32.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// +------------------------------------------------------------------------+
// | div_pkg : shared constants and state encodings for seq_divider_32      |
// | Rev 1.0 : initial release                                              |
// +------------------------------------------------------------------------+
`default_nettype none

package div_pkg;

  localparam int          ITER_CNT     = 32;
  localparam int          CNT_W        = 5;
  localparam logic [31:0] DBZ_QUOT_DEF = 32'hFFFF_FFFF;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_CALC  = 3'd1;
  localparam state_t S_DONE  = 3'd2;
  localparam state_t S_NEG_A = 3'd3;
  localparam state_t S_NEG_B = 3'd4;
  localparam state_t S_NEG_Q = 3'd5;
  localparam state_t S_NEG_R = 3'd6;

endpackage

`default_nettype wire

// File: rtl/Adder_32.sv
// +------------------------------------------------------------------------+
// | Adder_32 : 32-bit adder; cin=1 inverts b_pre, giving a - b_pre         |
// | Rev 1.0 : initial release                                              |
// +------------------------------------------------------------------------+
`default_nettype none

module Adder_32 (
  input  logic [31:0] a,
  input  logic [31:0] b_pre,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout,
  output logic        zero,
  output logic        ovf
);

  logic [31:0] b;

  assign b           = b_pre ^ {32{cin}};
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {32'd0, cin};
  assign zero        = (sum == 32'd0);
  assign ovf         = (a[31] == b[31]) && (sum[31] != a[31]);

endmodule

`default_nettype wire

// File: rtl/seq_divider_32.sv
// +------------------------------------------------------------------------+
// | seq_divider_32 : multi-cycle restoring divider on a shared Adder_32.   |
// | Optional SIGNED_DIV_EN adds two's-complement operand/result fix-up.    |
// | Rev 1.0 : initial release                                              |
// +------------------------------------------------------------------------+
`default_nettype none

module seq_divider_32
  import div_pkg::*;
#(
  parameter int          DW       = 32,
  parameter logic [31:0] DBZ_QUOT = DBZ_QUOT_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [DW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [DW-1:0] remainder,
  output logic          div_by_zero,
  output logic          busy
);

  generate
    if (DW != 32) begin : g_dw_check
      $error("seq_divider_32: DW must be 32");
    end
  endgenerate

  state_t           state_q, state_d;
  logic [DW-1:0]    r_q, r_d, q_q, q_d, d_q, d_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dbz_q, dbz_d;
`ifdef SIGNED_DIV_EN
  logic             neg_q_q, neg_q_d, neg_r_q, neg_r_d;
`endif

  logic [DW-1:0] add_a, add_b, add_sum;
  logic          add_cin, add_cout, zero_unused, ovf_unused;
  logic          msb, sub_ok;
  logic [DW-1:0] rs;

  Adder_32 u_adder (
    .a     (add_a),
    .b_pre (add_b),
    .cin   (add_cin),
    .sum   (add_sum),
    .cout  (add_cout),
    .zero  (zero_unused),
    .ovf   (ovf_unused)
  );

  // Bit 32 of the shifted remainder guarantees the subtraction fits.
  assign {msb, rs} = {r_q, q_q[DW-1]};
  assign sub_ok    = msb | add_cout;

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    dbz_d   = dbz_q;
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
`ifdef SIGNED_DIV_EN
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (divisor == '0) begin
            q_d     = DBZ_QUOT;
            r_d     = dividend;
            dbz_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            q_d     = dividend;
            r_d     = '0;
            d_d     = divisor;
            cnt_d   = '0;
            dbz_d   = 1'b0;
`ifdef SIGNED_DIV_EN
            neg_q_d = dividend[DW-1] ^ divisor[DW-1];
            neg_r_d = dividend[DW-1];
            state_d = S_NEG_A;
`else
            state_d = S_CALC;
`endif
          end
        end
      end
      S_CALC: begin
        add_a   = rs;
        add_b   = d_q;
        add_cin = 1'b1;
        r_d     = sub_ok ? add_sum : rs;
        q_d     = {q_q[DW-2:0], sub_ok};
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(ITER_CNT - 1)) begin
`ifdef SIGNED_DIV_EN
          state_d = S_NEG_Q;
`else
          state_d = S_DONE;
`endif
        end
      end
`ifdef SIGNED_DIV_EN
      // Each fix-up state costs one cycle whether or not it negates.
      S_NEG_A: begin
        add_b   = q_q;
        add_cin = 1'b1;
        if (neg_r_q) q_d = add_sum;
        state_d = S_NEG_B;
      end
      S_NEG_B: begin
        add_b   = d_q;
        add_cin = 1'b1;
        if (d_q[DW-1]) d_d = add_sum;
        state_d = S_CALC;
      end
      S_NEG_Q: begin
        add_b   = q_q;
        add_cin = 1'b1;
        if (neg_q_q) q_d = add_sum;
        state_d = S_NEG_R;
      end
      S_NEG_R: begin
        add_b   = r_q;
        add_cin = 1'b1;
        if (neg_r_q) r_d = add_sum;
        state_d = S_DONE;
      end
`endif
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      dbz_q   <= 1'b0;
`ifdef SIGNED_DIV_EN
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      dbz_q   <= dbz_d;
`ifdef SIGNED_DIV_EN
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
`endif
    end
  end

  assign in_ready    = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign out_valid   = (state_q == S_DONE);
  assign quotient    = q_q;
  assign remainder   = r_q;
  assign div_by_zero = dbz_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_divider_32.sv
// +------------------------------------------------------------------------+
// | tb_seq_divider_32 : scoreboard bench for seq_divider_32                |
// | Rev 1.0 : initial release                                              |
// +------------------------------------------------------------------------+
`default_nettype none

module tb_seq_divider_32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        in_ready, out_valid, div_by_zero, busy;
  logic [31:0] quotient, remainder;

`ifdef SIGNED_DIV_EN
  localparam int LAT = 36;
`else
  localparam int LAT = 32;
`endif

  typedef struct packed {
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
  } res_t;

  res_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  seq_divider_32 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  function automatic res_t model(input logic [31:0] a, input logic [31:0] b);
    res_t        res;
    logic [31:0] ua, ub;
    if (b == 32'd0) begin
      res.q   = 32'hFFFF_FFFF;
      res.r   = a;
      res.dbz = 1'b1;
      return res;
    end
`ifdef SIGNED_DIV_EN
    ua    = a[31] ? (32'd0 - a) : a;
    ub    = b[31] ? (32'd0 - b) : b;
    res.q = ua / ub;
    res.r = ua % ub;
    if (a[31] ^ b[31]) res.q = 32'd0 - res.q;
    if (a[31])         res.r = 32'd0 - res.r;
`else
    ua    = a;
    ub    = b;
    res.q = ua / ub;
    res.r = ua % ub;
`endif
    res.dbz = 1'b0;
    return res;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    while (!in_ready && n < 200) begin
      step();
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL issue_ready got in_ready=%0b want 1", in_ready);
    end
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    step();
    in_valid = 1'b0;
    exp_q.push_back(model(a, b));
  endtask

  // want_lat < 0 skips the latency comparison (response already pending).
  task automatic collect(input string name, input int want_lat);
    int   lat = 0;
    res_t e;
    while (!out_valid && lat < 100) begin
      step();
      lat++;
    end
    if (want_lat >= 0) begin
      checks++;
      if (lat != want_lat) begin
        errors++;
        $display("FAIL %s_latency got %0d want %0d", name, lat, want_lat);
      end
    end
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s_scoreboard got empty queue want one entry", name);
    end else begin
      e = exp_q.pop_front();
      if ({quotient, remainder, div_by_zero} !== e) begin
        errors++;
        $display("FAIL %s got q=%h r=%h dbz=%0b want q=%h r=%h dbz=%0b",
                 name, quotient, remainder, div_by_zero, e.q, e.r, e.dbz);
      end
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_handshake got out_valid=%0b in_ready=%0b want 0 1",
               name, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({quotient, remainder, div_by_zero, out_valid, busy} !== 67'd0) begin
      errors++;
      $display("FAIL reset_outputs got q=%h r=%h dbz=%0b ov=%0b busy=%0b want all 0",
               quotient, remainder, div_by_zero, out_valid, busy);
    end
    #10 rst_n = 1'b1;
    step();
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle got in_ready=%0b busy=%0b want 1 0", in_ready, busy);
    end
  endtask

  task automatic test_basic();
    issue(32'd100, 32'd7);
    collect("div_100_7", LAT);
  endtask

  task automatic test_msb_path();
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFE);
    collect("div_ffffffff_fffffffe", LAT);
    issue(32'hFFFF_FFFF, 32'h8000_0001);
    collect("div_ffffffff_80000001", LAT);
  endtask

  task automatic test_div_by_zero();
    issue(32'd55, 32'd0);
    collect("div_by_zero", 0);
  endtask

  task automatic test_backpressure();
    int n = 0;
    out_ready = 1'b0;
    issue(32'd1000, 32'd3);
    while (!out_valid && n < 100) begin
      step();
      n++;
    end
    in_valid = 1'b1;
    dividend = 32'd999;
    divisor  = 32'd9;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
          quotient !== exp_q[0].q || remainder !== exp_q[0].r) begin
        errors++;
        $display("FAIL stall_frozen got ov=%0b rdy=%0b q=%h r=%h want 1 0 %h %h",
                 out_valid, in_ready, quotient, remainder, exp_q[0].q, exp_q[0].r);
      end
    end
    in_valid = 1'b0;
    collect("stall_1000_3", -1);
    issue(32'd77, 32'd5);
    collect("after_stall_77_5", LAT);
  endtask

  task automatic test_reset_midop();
    issue(32'hABCD_1234, 32'h1000_0001);
    repeat (10) step();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({quotient, remainder, div_by_zero, out_valid, busy} !== 67'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midop_reset got q=%h r=%h dbz=%0b ov=%0b busy=%0b rdy=%0b want zeros rdy=1",
               quotient, remainder, div_by_zero, out_valid, busy, in_ready);
    end
    exp_q.delete();
    #2 rst_n = 1'b1;
    step();
    issue(32'd20, 32'd4);
    collect("after_reset_20_4", LAT);
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b;
    for (int i = 0; i < 4; i++) begin
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      issue(a, b);
      collect("random", (b == 32'd0) ? 0 : LAT);
    end
  endtask

`ifdef SIGNED_DIV_EN
  task automatic test_signed();
    issue(32'hFFFF_FFF9, 32'd2);
    collect("signed_m7_2", LAT);
    issue(32'h8000_0000, 32'hFFFF_FFFF);
    collect("signed_min_m1", LAT);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_msb_path();
    test_div_by_zero();
    test_backpressure();
    test_reset_midop();
    test_back_to_back();
`ifdef SIGNED_DIV_EN
    test_signed();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
